// File: rtl/instruction_count_register.sv
// ---------------------------------------------------------------------------
// instruction_count_register
//
// Retired-instruction counter for the CPU datapath/control. It holds a
// WIDTH-bit unsigned count that advances by one on every rising clock edge
// where the control unit asserts update_count. The count wraps modulo
// 2^WIDTH, and a sticky overflow flag records that at least one wrap has
// happened since the last reset.
//
// Ports:
//   clk          in   1      system clock; all state updates on rising edge
//   reset        in   1      synchronous, active-high clear (wins over update)
//   update_count in   1      increment enable, level-sensitive per cycle
//   count_out    out  WIDTH  current count, straight from the register
//   overflow     out  1      sticky wrap flag, cleared only by reset
// ---------------------------------------------------------------------------
module instruction_count_register #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update_count,
    output logic [WIDTH-1:0] count_out,
    output logic             overflow
);

    logic [WIDTH-1:0] count_q;
    logic             overflow_q;
    logic [WIDTH-1:0] count_inc;
    logic             carry;

    // The carry out of the +1 is exactly the all-ones -> zero wrap event,
    // so no separate all-ones compare is needed.
    always_comb begin
        {carry, count_inc} = {1'b0, count_q} + {{WIDTH{1'b0}}, 1'b1};
    end

    // Only a definite 1 on update_count advances the count. An X/Z enable
    // makes the if-condition false in simulation, so the register holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (update_count == 1'b1) begin
            count_q <= count_inc;
            if (carry) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign count_out = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_instruction_count_register.sv
// ---------------------------------------------------------------------------
// tb_instruction_count_register
//
// Self-checking bench for instruction_count_register. The DUT runs with a
// narrow WIDTH so wrap-around is reached quickly. Expected values come from
// an integer reference model: count is (count + 1) mod 2^W on an enabled
// edge, overflow latches whenever the unbounded sum reaches 2^W.
// ---------------------------------------------------------------------------
module tb_instruction_count_register;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         reset;
    logic         update_count;
    logic [W-1:0] count_out;
    logic         overflow;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int ref_count = 0;
    int ref_ovf   = 0;

    instruction_count_register #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .update_count (update_count),
        .count_out    (count_out),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle, advance the model on the edge, then check #1 after it.
    task automatic tick(input logic rst, input logic en, input string tag);
        reset        = rst;
        update_count = en;
        @(posedge clk);
        if (rst) begin
            ref_count = 0;
            ref_ovf   = 0;
        end else if (en === 1'b1) begin
            if (ref_count + 1 >= MOD) ref_ovf = 1;
            ref_count = (ref_count + 1) % MOD;
        end
        #1;
        chk({tag, ".count"}, int'(count_out), ref_count);
        chk({tag, ".ovf"},   int'(overflow),  ref_ovf);
    endtask

    initial begin
        reset        = 1'b1;
        update_count = 1'b0;

        // reset with enable low and high
        tick(1'b1, 1'b0, "rst_en0");
        tick(1'b1, 1'b1, "rst_en1");
        chk("rst_const", int'(count_out), 0);

        // single increments: 1, 1, 2, 3
        tick(1'b0, 1'b1, "inc_a");
        tick(1'b0, 1'b0, "inc_b");
        tick(1'b0, 1'b1, "inc_c");
        tick(1'b0, 1'b1, "inc_d");
        chk("inc_const", int'(count_out), 3);

        // hold five cycles, then one increment
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, "hold");
        tick(1'b0, 1'b1, "hold_inc");
        chk("hold_const", int'(count_out), 4);

        // reset wins over update on the same edge
        tick(1'b1, 1'b1, "rst_prio");
        chk("rst_prio_const", int'(count_out), 0);
        tick(1'b0, 1'b1, "after_prio");

        // count up to all-ones minus one, then wrap twice through zero
        while (ref_count != MOD - 2) tick(1'b0, 1'b1, "preload");
        tick(1'b0, 1'b1, "to_ones");
        chk("ones_const", int'(count_out), MOD - 1);
        chk("ones_ovf_const", int'(overflow), 0);
        tick(1'b0, 1'b1, "wrap0");
        chk("wrap0_ovf_const", int'(overflow), 1);
        tick(1'b0, 1'b1, "wrap1");
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, "ovf_hold");
        tick(1'b1, 1'b0, "ovf_clear");
        chk("ovf_clear_const", int'(overflow), 0);

        // unknown enable at count 7 must hold
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, "to7");
        tick(1'b0, 1'bx, "en_x");
        chk("en_x_const", int'(count_out), 7);

        // randomized traffic: frequent wraps, occasional resets
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 7), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_count_register.md
Name:
instruction_count_register

Overview:
- Retired-instruction counter for the CPU datapath/control.
- Holds a WIDTH-bit count that increments by one on each clock edge where the control unit asserts update_count.
- count_out feeds debug/performance readout logic.
- Synchronous clear via reset; wraps modulo 2^WIDTH and flags wrap events on a sticky overflow bit.

Parameters:
- WIDTH, 16, bit width of the counter and of count_out.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high clear.
- update_count  input  1  increment enable; sampled on the rising edge of clk.
- count_out  output  WIDTH  current count, driven directly from the register (no combinational path from inputs).
- overflow  output  1  sticky flag, set when the counter wraps from all-ones to zero. May be left unconnected.

Behaviour:
- All state is registered; no asynchronous paths. Reset is the one clock and synchronous active-high input as already decided.
- Reset:
  - On a rising edge with reset=1: count_out <= 0 and overflow <= 0.
  - Reset has priority over update_count.
  - Reset mid-count discards the accumulated value.
- Increment:
  - On a rising edge with reset=0 and update_count=1: count_out <= count_out + 1.
  - The new value is visible one cycle after the enable is sampled; no combinational bypass.
- Hold: on a rising edge with reset=0 and update_count=0, count_out and overflow are unchanged.
- Consecutive enables: update_count held high for N rising edges adds exactly N. There is no edge detection; the input is level-sensitive per cycle.
- Wrap-around:
  - At count_out = 2^WIDTH-1 (0xFFFF for the default) with update_count=1, the next value is 0 and overflow <= 1.
  - overflow stays 1 until reset.
  - Further wraps keep overflow at 1.
- Unknown input: if update_count is X/Z at a non-reset edge, the register holds its value. Only update_count==1 increments.
- Power-up: count_out is undefined until the first reset edge. Benches must assert reset for at least one rising edge.
- Arithmetic: unsigned, modulo 2^WIDTH; no saturation.

Test Plan:
- Reset: reset=1 for one rising edge with update_count=0 or 1 -> count_out=0, overflow=0 on the next sample.
- Single increments: after reset, update_count=1 for one cycle, 0 for one cycle, then 1 for two cycles -> count_out sequence 1, 1, 2, 3.
- Hold: update_count=0 for 5 cycles at count 3 -> count_out stays 3. Then update_count=1 for one cycle -> count_out=4.
- Reset priority: count at 4, reset=1 and update_count=1 on the same edge -> count_out=0 (not 5). The following edge with update_count=1 gives 1.
- Wrap: preload by counting to 0xFFFE (or use WIDTH=4 to reach 0xE), then hold update_count=1:
  - -> 0xFFFF with overflow=0;
  - -> 0x0000 with overflow=1;
  - -> 0x0001 with overflow still 1.
  - Reset then clears overflow to 0.
- Unknown enable: update_count=X for one edge at count 7 -> count_out remains 7.
